fp_mul_seq: RTL

Iterative radix-2 shift-add floating-point multiplier: the multiply counterpart to the FPU's combinational divider, handling the same IEEE-754 formats (binary64 or binary32), special-case encodings and rounding style. It sits in the FPU beside the divider and trades latency for area, using one mantissa add per cycle. Operands enter and results leave through valid/ready handshakes, so the FPU issue logic can stall on it.

---
 rtl/fp_pkg.sv | 61 ++++++
 rtl/fp_special_case.sv | 60 ++++++
 rtl/fp_mul_seq.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point definitions: format sizes, special encodings,
// sequencer state encoding and exception bit positions.
package fp_pkg;

    localparam int MANTISSA_SIZE_64 = 52;
    localparam int EXPONENT_SIZE_64 = 11;
    localparam int BIAS_64          = 1023;

    localparam int MANTISSA_SIZE_32 = 23;
    localparam int EXPONENT_SIZE_32 = 8;
    localparam int BIAS_32          = 127;

    localparam logic [63:0] NAN_64        = 64'h7ff8000000000000;
    localparam logic [63:0] INFINITY_P_64 = 64'h7ff0000000000000;
    localparam logic [63:0] INFINITY_N_64 = 64'hfff0000000000000;
    localparam logic [63:0] ZERO_64       = 64'h0000000000000000;

    localparam logic [31:0] NAN_32        = 32'h7fc00000;
    localparam logic [31:0] INFINITY_P_32 = 32'h7f800000;
    localparam logic [31:0] INFINITY_N_32 = 32'hff800000;
    localparam logic [31:0] ZERO_32       = 32'h00000000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    // exc = {invalid, overflow, underflow}
    localparam int EXC_INVALID   = 2;
    localparam int EXC_OVERFLOW  = 1;
    localparam int EXC_UNDERFLOW = 0;

    function automatic int mantissa_size(input int bw);
        return (bw == 32) ? MANTISSA_SIZE_32 : MANTISSA_SIZE_64;
    endfunction

    function automatic int exponent_size(input int bw);
        return (bw == 32) ? EXPONENT_SIZE_32 : EXPONENT_SIZE_64;
    endfunction

    function automatic int bias_of(input int bw);
        return (bw == 32) ? BIAS_32 : BIAS_64;
    endfunction

    // Encodings are returned zero-extended to 64 bits; callers keep the low BUS_WIDTH bits.
    function automatic logic [63:0] nan_bits(input int bw);
        return (bw == 32) ? {32'h0, NAN_32} : NAN_64;
    endfunction

    function automatic logic [63:0] inf_bits(input int bw, input logic neg);
        if (bw == 32) return neg ? {32'h0, INFINITY_N_32} : {32'h0, INFINITY_P_32};
        return neg ? INFINITY_N_64 : INFINITY_P_64;
    endfunction

    function automatic logic [63:0] zero_bits(input int bw);
        return (bw == 32) ? {32'h0, ZERO_32} : ZERO_64;
    endfunction

endpackage

// File: rtl/fp_special_case.sv
// Combinational classifier for operand pairs whose product is fixed by the
// encodings alone (NaN, infinity, zero). Shared with the divider.
import fp_pkg::*;

module fp_special_case #(
    parameter int BUS_WIDTH = 64
) (
    input  logic [BUS_WIDTH-1:0] in1,
    input  logic [BUS_WIDTH-1:0] in2,
    output logic                 is_special,
    output logic [BUS_WIDTH-1:0] special_out,
    output logic [2:0]           special_exc
);

    localparam int MS = mantissa_size(BUS_WIDTH);
    localparam int ES = exponent_size(BUS_WIDTH);

    localparam logic [63:0] NAN_W   = nan_bits(BUS_WIDTH);
    localparam logic [63:0] INF_P_W = inf_bits(BUS_WIDTH, 1'b0);
    localparam logic [63:0] INF_N_W = inf_bits(BUS_WIDTH, 1'b1);
    localparam logic [63:0] ZERO_W  = zero_bits(BUS_WIDTH);

    logic          s1, s2;
    logic [ES-1:0] e1, e2;
    logic [MS-1:0] m1, m2;
    logic          nan1, nan2, inf1, inf2, zero1, zero2;

    assign s1 = in1[BUS_WIDTH-1];
    assign s2 = in2[BUS_WIDTH-1];
    assign e1 = in1[BUS_WIDTH-2 -: ES];
    assign e2 = in2[BUS_WIDTH-2 -: ES];
    assign m1 = in1[MS-1:0];
    assign m2 = in2[MS-1:0];

    // Subnormals (E==0, M!=0) count as zero: they are flushed on input.
    assign nan1  = (&e1) && (|m1);
    assign nan2  = (&e2) && (|m2);
    assign inf1  = (&e1) && !(|m1);
    assign inf2  = (&e2) && !(|m2);
    assign zero1 = !(|e1);
    assign zero2 = !(|e2);

    // Priority: invalid first, then infinity, then zero.
    always_comb begin
        is_special  = 1'b0;
        special_out = ZERO_W[BUS_WIDTH-1:0];
        special_exc = 3'b000;
        if (nan1 || nan2 || (inf1 && zero2) || (zero1 && inf2)) begin
            is_special               = 1'b1;
            special_out              = NAN_W[BUS_WIDTH-1:0];
            special_exc[EXC_INVALID] = 1'b1;
        end else if (inf1 || inf2) begin
            is_special  = 1'b1;
            special_out = (s1 ^ s2) ? INF_N_W[BUS_WIDTH-1:0] : INF_P_W[BUS_WIDTH-1:0];
        end else if (zero1 || zero2) begin
            is_special = 1'b1;
        end
    end

endmodule

// File: rtl/fp_mul_seq.sv
// Iterative radix-2 shift-add floating-point multiplier with valid/ready
// handshakes on both sides.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for operands, in_ready=1
//   MUL   | one shift-add step per cycle, counter 0..MANTISSA_SIZE
//   NORM  | normalise, round on guard bit, range check
//   DONE  | result held on out/exc, out_valid=1 until out_ready
import fp_pkg::*;

module fp_mul_seq #(
    parameter int BUS_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BUS_WIDTH-1:0] in1,
    input  logic [BUS_WIDTH-1:0] in2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BUS_WIDTH-1:0] out,
    output logic [2:0]           exc
);

    localparam int MS   = mantissa_size(BUS_WIDTH);
    localparam int ES   = exponent_size(BUS_WIDTH);
    localparam int BIAS = bias_of(BUS_WIDTH);
    localparam int CW   = $clog2(MS + 1);
    // Product bits below the guard position never feed back into the upper
    // half, so only product[2*MS+1 : MS-1] is kept; lower bits shift out.
    localparam int AW   = MS + 3;
    localparam int EXP_OVF_I = 2 * BIAS + 1;

    localparam logic signed [ES+1:0] BIAS_S   = BIAS[ES+1:0];
    localparam logic signed [ES+1:0] EXP_OVF  = EXP_OVF_I[ES+1:0];
    localparam logic [CW-1:0]        CNT_LAST = MS[CW-1:0];

    localparam logic [63:0] INF_P_W = inf_bits(BUS_WIDTH, 1'b0);
    localparam logic [63:0] INF_N_W = inf_bits(BUS_WIDTH, 1'b1);
    localparam logic [63:0] ZERO_W  = zero_bits(BUS_WIDTH);

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [MS:0]            mcand_q, mcand_d;
    logic [MS:0]            mplier_q, mplier_d;
    logic [AW-1:0]          acc_q, acc_d;
    logic signed [ES+1:0]   exp_q, exp_d;
    logic                   sign_q, sign_d;
    logic [BUS_WIDTH-1:0]   out_q, out_d;
    logic [2:0]             exc_q, exc_d;

    logic                   sp_is_special;
    logic [BUS_WIDTH-1:0]   sp_out;
    logic [2:0]             sp_exc;

    logic signed [ES+1:0]   exp_sum;
    logic [MS+1:0]          step_sum;
    logic [AW-1:0]          acc_step;

    logic [MS-1:0]          norm_mant;
    logic                   norm_guard;
    logic signed [ES+1:0]   norm_exp;
    logic [MS:0]            rnd_mant;
    logic signed [ES+1:0]   fin_exp;
    logic [BUS_WIDTH-1:0]   norm_out;
    logic [2:0]             norm_exc;

    fp_special_case #(
        .BUS_WIDTH (BUS_WIDTH)
    ) u_special (
        .in1         (in1),
        .in2         (in2),
        .is_special  (sp_is_special),
        .special_out (sp_out),
        .special_exc (sp_exc)
    );

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out       = out_q;
    assign exc       = exc_q;

    assign exp_sum = $signed({2'b00, in1[BUS_WIDTH-2 -: ES]})
                   + $signed({2'b00, in2[BUS_WIDTH-2 -: ES]}) - BIAS_S;

    // One shift-add step: add multiplicand into the top when multiplier LSB is set, then shift right.
    always_comb begin
        step_sum = {1'b0, acc_q[AW-1:2]} + {1'b0, (mplier_q[0] ? mcand_q : {(MS+1){1'b0}})};
        acc_step = {step_sum, acc_q[1]};
    end

    // Normalise, round to nearest on the guard bit (ties away), and range-check the product.
    always_comb begin
        if (acc_q[AW-1]) begin
            norm_mant  = acc_q[AW-2 -: MS];
            norm_guard = acc_q[1];
        end else begin
            norm_mant  = acc_q[AW-3 -: MS];
            norm_guard = acc_q[0];
        end
        norm_exp = exp_q + $signed({{(ES+1){1'b0}}, acc_q[AW-1]});
        rnd_mant = {1'b0, norm_mant} + {{MS{1'b0}}, norm_guard};
        // A carry out of rounding means 2.0: mantissa field is already zero, only the exponent moves.
        fin_exp  = norm_exp + $signed({{(ES+1){1'b0}}, rnd_mant[MS]});

        norm_exc = 3'b000;
        if (fin_exp >= EXP_OVF) begin
            norm_out               = sign_q ? INF_N_W[BUS_WIDTH-1:0] : INF_P_W[BUS_WIDTH-1:0];
            norm_exc[EXC_OVERFLOW] = 1'b1;
        end else if (fin_exp[ES+1] || (fin_exp == '0)) begin
            norm_out                = ZERO_W[BUS_WIDTH-1:0];
            norm_exc[EXC_UNDERFLOW] = 1'b1;
        end else begin
            norm_out = {sign_q, fin_exp[ES-1:0], rnd_mant[MS-1:0]};
        end
    end

    // Next-state and datapath load/update decisions.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        out_d    = out_q;
        exc_d    = exc_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d = in1[BUS_WIDTH-1] ^ in2[BUS_WIDTH-1];
                    if (sp_is_special) begin
                        out_d   = sp_out;
                        exc_d   = sp_exc;
                        state_d = DONE;
                    end else begin
                        mcand_d  = {1'b1, in1[MS-1:0]};
                        mplier_d = {1'b1, in2[MS-1:0]};
                        acc_d    = '0;
                        cnt_d    = '0;
                        exp_d    = exp_sum;
                        state_d  = MUL;
                    end
                end
            end
            MUL: begin
                acc_d    = acc_step;
                mplier_d = {1'b0, mplier_q[MS:1]};
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = NORM;
            end
            NORM: begin
                out_d   = norm_out;
                exc_d   = norm_exc;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            out_q    <= '0;
            exc_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            out_q    <= out_d;
            exc_q    <= exc_d;
        end
    end

endmodule
